// File: rtl/bitcnt_pkg.sv
// Shared definitions for the sequential bit-count unit: operation encodings and FSM states.
package bitcnt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [2:0] FUNC_CLZ64  = 3'b000;
  localparam logic [2:0] FUNC_CLZ32  = 3'b001;
  localparam logic [2:0] FUNC_CTZ64  = 3'b010;
  localparam logic [2:0] FUNC_CTZ32  = 3'b011;
  localparam logic [2:0] FUNC_PCNT64 = 3'b100;
  localparam logic [2:0] FUNC_PCNT32 = 3'b101;

endpackage

// File: rtl/bitcnt_prep.sv
// Combinational operand preprocessing: turns CLZ/CTZ/PCNT into a plain popcount of one word.
module bitcnt_prep
  import bitcnt_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [2:0]      i_func,
  output logic [XLEN-1:0] o_word
);

  logic            w_half;
  logic            w_is_clz;
  logic            w_is_ctz;
  logic            w_is_pcnt;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_masked;
  logic [XLEN-1:0] w_rev;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_tz;

  always_comb begin
    w_half    = (XLEN == 64) && i_func[0];
    w_is_clz  = (i_func == FUNC_CLZ64)  || (i_func == FUNC_CLZ32);
    w_is_ctz  = (i_func == FUNC_CTZ64)  || (i_func == FUNC_CTZ32);
    w_is_pcnt = (i_func == FUNC_PCNT64) || (i_func == FUNC_PCNT32);

    w_mask = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_mask[i] = !w_half || (i < 32);
    end
    w_masked = i_data & w_mask;

    w_rev = '0;
    if (w_half) begin
      for (int i = 0; i < 32; i++) w_rev[i] = w_masked[31-i];
    end else begin
      for (int i = 0; i < XLEN; i++) w_rev[i] = w_masked[XLEN-1-i];
    end

    // (x-1)&~x leaves ones exactly on the trailing zeros; a zero operand yields W ones.
    w_src = w_is_clz ? w_rev : w_masked;
    w_tz  = ((w_src - XLEN'(1)) & ~w_src) & w_mask;

    o_word = '0;
    if (w_is_clz || w_is_ctz) begin
      o_word = w_tz;
    end else if (w_is_pcnt) begin
      o_word = w_masked;
    end
  end

endmodule

// File: rtl/bitcnt_seq.sv
// Multi-cycle bit counter: latches a preprocessed word, then popcounts CHUNK bits per cycle.
module bitcnt_seq
  import bitcnt_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [XLEN-1:0] din_data,
  input  logic [2:0]      din_func,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_data
);

  localparam int unsigned K    = XLEN / CHUNK;
  localparam int unsigned ACCW = $clog2(XLEN + 1);
  localparam int unsigned CNTW = (K > 1) ? $clog2(K) : 1;

  state_e          r_state;
  logic [XLEN-1:0] r_word;
  logic [ACCW-1:0] r_acc;
  logic [CNTW-1:0] r_cnt;

  logic [XLEN-1:0]  w_prep;
  logic [CHUNK-1:0] w_slice;
  logic [ACCW-1:0]  w_pop;

  bitcnt_prep #(
    .XLEN(XLEN)
  ) u_prep (
    .i_data(din_data),
    .i_func(din_func),
    .o_word(w_prep)
  );

  always_comb begin
    w_slice = CHUNK'(r_word >> (CHUNK * int'(r_cnt)));
    w_pop   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_pop = w_pop + ACCW'(w_slice[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (din_valid) begin
            r_word  <= w_prep;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          r_acc <= r_acc + w_pop;
          r_cnt <= r_cnt + CNTW'(1);
          if (r_cnt == CNTW'(K - 1)) r_state <= StDone;
        end
        StDone: begin
          if (dout_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign din_ready  = (r_state == StIdle);
  assign dout_valid = (r_state == StDone);
  assign dout_data  = {{(XLEN - ACCW){1'b0}}, r_acc};

endmodule

// File: tb/tb_bitcnt_seq.sv
// Directed and reference-model checks of bitcnt_seq at XLEN=64/CHUNK=8 and XLEN=32/CHUNK=32.
module tb_bitcnt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        dout_ready;
  logic [2:0]  din_func;
  logic [63:0] din_data;
  logic        sel;

  logic        rdy64, vld64, rdy32, vld32;
  logic [63:0] data64;
  logic [31:0] data32;
  logic        o_rdy, o_vld;
  logic [63:0] o_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bitcnt_seq #(
    .XLEN (64),
    .CHUNK(8)
  ) u_dut64 (
    .clock     (clk),
    .reset     (rst),
    .din_valid (din_valid && !sel),
    .din_ready (rdy64),
    .din_data  (din_data),
    .din_func  (din_func),
    .dout_valid(vld64),
    .dout_ready(dout_ready && !sel),
    .dout_data (data64)
  );

  bitcnt_seq #(
    .XLEN (32),
    .CHUNK(32)
  ) u_dut32 (
    .clock     (clk),
    .reset     (rst),
    .din_valid (din_valid && sel),
    .din_ready (rdy32),
    .din_data  (din_data[31:0]),
    .din_func  (din_func),
    .dout_valid(vld32),
    .dout_ready(dout_ready && sel),
    .dout_data (data32)
  );

  assign o_rdy  = sel ? rdy32 : rdy64;
  assign o_vld  = sel ? vld32 : vld64;
  assign o_data = sel ? {32'b0, data32} : data64;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Independent scan-based reference count.
  function automatic int ref_count(input logic [2:0] f, input logic [63:0] d, input int xlen);
    int w;
    int n;
    logic [1:0] op;
    w  = (xlen == 64 && f[0]) ? 32 : xlen;
    n  = 0;
    op = f[2:1];
    case (op)
      2'b00: begin
        for (int i = w - 1; i >= 0; i--) begin
          if (d[i]) break;
          n++;
        end
      end
      2'b01: begin
        for (int i = 0; i < w; i++) begin
          if (d[i]) break;
          n++;
        end
      end
      2'b10: begin
        for (int i = 0; i < w; i++) if (d[i]) n++;
      end
      default: n = 0;
    endcase
    return n;
  endfunction

  // Offer one op at a negedge, time it, optionally stall in DONE, then pop.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] d,
                        input logic [63:0] exp, input int hold);
    int lat;
    int k;
    logic [63:0] junk;
    k   = sel ? 1 : 8;
    lat = 0;
    while (!o_rdy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "/din_ready"}, 64'(o_rdy), 64'd1);
    din_valid = 1'b1;
    din_func  = f;
    din_data  = d;
    @(negedge clk);
    din_valid = 1'b0;
    junk      = {$urandom, $urandom};
    din_func  = 3'($urandom);
    din_data  = junk;
    lat = 1;
    while (!o_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "/latency"}, 64'(lat), 64'(k + 1));
    check_eq({tag, "/data"}, o_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "/hold_data"}, o_data, exp);
      check_eq({tag, "/hold_vld"}, 64'(o_vld), 64'd1);
      check_eq({tag, "/hold_rdy"}, 64'(o_rdy), 64'd0);
    end
    dout_ready = 1'b1;
    if (hold > 0) check_eq({tag, "/pop_rdy"}, 64'(o_rdy), 64'd0);
    @(negedge clk);
    dout_ready = 1'b0;
    check_eq({tag, "/after_pop_vld"}, 64'(o_vld), 64'd0);
    check_eq({tag, "/after_pop_rdy"}, 64'(o_rdy), 64'd1);
  endtask

  initial begin
    logic [2:0]  f;
    logic [63:0] d;
    rst        = 1'b1;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    din_func   = 3'b000;
    din_data   = '0;
    sel        = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst64/rdy", 64'(rdy64), 64'd1);
    check_eq("rst64/vld", 64'(vld64), 64'd0);
    check_eq("rst64/data", data64, 64'd0);
    check_eq("rst32/rdy", 64'(rdy32), 64'd1);
    check_eq("rst32/vld", 64'(vld32), 64'd0);
    check_eq("rst32/data", 64'(data32), 64'd0);

    run_op("clz64_1",      3'b000, 64'h0000_0000_0000_0001, 64'd63, 0);
    run_op("ctz32_hi",     3'b011, 64'hFFFF_FFFF_0000_0000, 64'd32, 0);
    run_op("clz64_0",      3'b000, 64'h0,                   64'd64, 0);
    run_op("clz32_0",      3'b001, 64'hFFFF_FFFF_0000_0000, 64'd32, 0);
    run_op("ctz64_msb",    3'b010, 64'h8000_0000_0000_0000, 64'd63, 0);
    run_op("pcnt64_ones",  3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 0);
    run_op("pcnt32_ones",  3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd32, 0);
    run_op("func110",      3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,  0);
    run_op("clz32_hold",   3'b001, 64'hFFFF_0000_0001_0000, 64'd15, 5);

    // Reset in the 4th BUSY cycle, with a competing din_valid.
    din_valid = 1'b1;
    din_func  = 3'b000;
    din_data  = 64'h1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    check_eq("busy_rst/rdy", 64'(rdy64), 64'd1);
    check_eq("busy_rst/vld", 64'(vld64), 64'd0);
    check_eq("busy_rst/data", data64, 64'd0);
    repeat (10) @(negedge clk);
    check_eq("busy_rst/no_result", 64'(vld64), 64'd0);
    run_op("pcnt64_f0", 3'b100, 64'h0000_0000_0000_00F0, 64'd4, 0);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 25; i++) begin
        f = 3'($urandom_range(0, 7));
        d = {$urandom, $urandom};
        if (i % 5 == 0) d = '0;
        if (i % 5 == 1) d = 64'h1 << $urandom_range(0, 63);
        if (sel) d[63:32] = '0;
        run_op(sel ? "rand32" : "rand64", f, d, 64'(ref_count(f, d, sel ? 32 : 64)), i % 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
